exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage.sv | 144 ++++++++++++++
 tb/tb_exec_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU (add/sub/logic/compare/shift) and a 32-cycle shift-add multiplier.
// Latency: 1 cycle for ALU and illegal ops; MUL/MULHU present their result 32 cycles after acceptance.
// Backpressure: valid/ready on both sides; the output register holds while out_ready=0, and in_ready drops while the multiplier runs.
// Ports: clk, rst_n (sync, active-low), flush | in_valid/in_ready, in_op, in_a, in_b, in_rd
//        | out_valid/out_ready, out_result, out_rd, out_carry, out_illegal
module exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_carry,
  output logic        out_illegal
);

  typedef enum logic {IDLE, MUL} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic        mul_hi_q;
  logic [4:0]  mul_rd_q;

  logic        accept;
  logic        is_mul;
  logic        mul_last;
  logic [32:0] add33, sub33, prod_sum;
  logic [31:0] alu_res;
  logic        alu_carry;
  logic        alu_illegal;
  logic [31:0] partial;
  logic [63:0] acc_next;

  // State register is the only thing driven here; the datapath lives below.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    accept   = in_valid && in_ready && !flush;
    is_mul   = (in_op == 4'd10) || (in_op == 4'd11);
    mul_last = (state_q == MUL) && (cnt_q == 5'd31);
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_last)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Single-cycle ALU. SUB is a + ~b + 1 so bit 32 is the "no borrow" flag (a >= b unsigned).
  always_comb begin
    add33       = {1'b0, in_a} + {1'b0, in_b};
    sub33       = {1'b0, in_a} + {1'b0, ~in_b} + 33'd1;
    alu_res     = 32'd0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (in_op)
      4'd0:  begin alu_res = add33[31:0]; alu_carry = add33[32]; end
      4'd1:  begin alu_res = sub33[31:0]; alu_carry = sub33[32]; end
      4'd2:  alu_res = in_a & in_b;
      4'd3:  alu_res = in_a | in_b;
      4'd4:  alu_res = in_a ^ in_b;
      4'd5:  alu_res = {31'd0, $signed(in_a) < $signed(in_b)};
      4'd6:  alu_res = {31'd0, in_a < in_b};
      4'd7:  alu_res = in_a << in_b[4:0];
      4'd8:  alu_res = in_a >> in_b[4:0];
      4'd9:  alu_res = $unsigned($signed(in_a) >>> in_b[4:0]);
      4'd10, 4'd11: alu_res = 32'd0;
      default: alu_illegal = 1'b1;
    endcase
  end

  // One multiplier bit per cycle: add the multiplicand into the upper half when the current
  // LSB is set, then shift the whole accumulator right. After 32 steps acc holds a*b.
  always_comb begin
    partial  = mplier_q[0] ? mcand_q : 32'd0;
    prod_sum = {1'b0, acc_q[63:32]} + {1'b0, partial};
    acc_next = {prod_sum, acc_q[31:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= 5'd0;
      acc_q       <= 64'd0;
      mcand_q     <= 32'd0;
      mplier_q    <= 32'd0;
      mul_hi_q    <= 1'b0;
      mul_rd_q    <= 5'd0;
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_rd      <= 5'd0;
      out_carry   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      cnt_q     <= 5'd0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out_valid   <= 1'b1;
        out_result  <= alu_res;
        out_rd      <= in_rd;
        out_carry   <= alu_carry;
        out_illegal <= alu_illegal;
      end
      if (accept && is_mul) begin
        acc_q    <= 64'd0;
        mcand_q  <= in_a;
        mplier_q <= in_b;
        cnt_q    <= 5'd0;
        mul_hi_q <= (in_op == 4'd11);
        mul_rd_q <= in_rd;
      end
      if (state_q == MUL) begin
        acc_q    <= acc_next;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 5'd1;
        // out_valid is already low here: the MUL was only accepted with the output register free.
        if (mul_last) begin
          out_valid   <= 1'b1;
          out_result  <= mul_hi_q ? acc_next[63:32] : acc_next[31:0];
          out_rd      <= mul_rd_q;
          out_carry   <= 1'b0;
          out_illegal <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_carry, out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  exec_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_carry(out_carry), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
  endtask

  // op, a, b, expected result, expected carry, expected illegal
  logic [3:0]  v_op  [12];
  logic [31:0] v_a   [12];
  logic [31:0] v_b   [12];
  logic [31:0] v_res [12];
  logic        v_c   [12];
  logic        v_ill [12];

  initial begin
    v_op[0]  = 4'd0;  v_a[0]  = 32'hFFFFFFFF; v_b[0]  = 32'h00000001; v_res[0]  = 32'h00000000; v_c[0]  = 1; v_ill[0]  = 0;
    v_op[1]  = 4'd2;  v_a[1]  = 32'hF0F0F0F0; v_b[1]  = 32'hFF00FF00; v_res[1]  = 32'hF000F000; v_c[1]  = 0; v_ill[1]  = 0;
    v_op[2]  = 4'd3;  v_a[2]  = 32'hF0F0F0F0; v_b[2]  = 32'h0F0F0000; v_res[2]  = 32'hFFFFF0F0; v_c[2]  = 0; v_ill[2]  = 0;
    v_op[3]  = 4'd4;  v_a[3]  = 32'hAAAA5555; v_b[3]  = 32'hFFFF0000; v_res[3]  = 32'h55555555; v_c[3]  = 0; v_ill[3]  = 0;
    v_op[4]  = 4'd5;  v_a[4]  = 32'h80000000; v_b[4]  = 32'h00000001; v_res[4]  = 32'h00000001; v_c[4]  = 0; v_ill[4]  = 0;
    v_op[5]  = 4'd6;  v_a[5]  = 32'h80000000; v_b[5]  = 32'h00000001; v_res[5]  = 32'h00000000; v_c[5]  = 0; v_ill[5]  = 0;
    v_op[6]  = 4'd5;  v_a[6]  = 32'h00000001; v_b[6]  = 32'h80000000; v_res[6]  = 32'h00000000; v_c[6]  = 0; v_ill[6]  = 0;
    v_op[7]  = 4'd7;  v_a[7]  = 32'h00000001; v_b[7]  = 32'h00000024; v_res[7]  = 32'h00000010; v_c[7]  = 0; v_ill[7]  = 0;
    v_op[8]  = 4'd8;  v_a[8]  = 32'h80000000; v_b[8]  = 32'h0000003F; v_res[8]  = 32'h00000001; v_c[8]  = 0; v_ill[8]  = 0;
    v_op[9]  = 4'd9;  v_a[9]  = 32'h80000000; v_b[9]  = 32'h00000021; v_res[9]  = 32'hC0000000; v_c[9]  = 0; v_ill[9]  = 0;
    v_op[10] = 4'd13; v_a[10] = 32'h00001234; v_b[10] = 32'h00000005; v_res[10] = 32'h00000000; v_c[10] = 0; v_ill[10] = 1;
    v_op[11] = 4'd1;  v_a[11] = 32'h00000000; v_b[11] = 32'h00000000; v_res[11] = 32'h00000000; v_c[11] = 1; v_ill[11] = 0;

    // Reset
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 4'd0; in_a = 32'd0; in_b = 32'd0; in_rd = 5'd0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_carry", {31'd0, out_carry}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // SUB pair, back to back
    out_ready = 1'b1;
    drive(4'd1, 32'd5, 32'd7, 5'd3);
    step();
    chk("sub57_valid", {31'd0, out_valid}, 32'd1);
    chk("sub57_result", out_result, 32'hFFFFFFFE);
    chk("sub57_carry", {31'd0, out_carry}, 32'd0);
    chk("sub57_rd", {27'd0, out_rd}, 32'd3);
    drive(4'd1, 32'd7, 32'd5, 5'd4);
    step();
    chk("sub75_valid", {31'd0, out_valid}, 32'd1);
    chk("sub75_result", out_result, 32'd2);
    chk("sub75_carry", {31'd0, out_carry}, 32'd1);
    chk("sub75_rd", {27'd0, out_rd}, 32'd4);

    // Single-cycle vector table, one op per cycle
    for (int i = 0; i < 12; i++) begin
      drive(v_op[i], v_a[i], v_b[i], 5'(i + 10));
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), out_result, v_res[i]);
      chk($sformatf("vec%0d_carry", i), {31'd0, out_carry}, {31'd0, v_c[i]});
      chk($sformatf("vec%0d_illegal", i), {31'd0, out_illegal}, {31'd0, v_ill[i]});
      chk($sformatf("vec%0d_rd", i), {27'd0, out_rd}, 32'(i + 10));
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // MUL low word
    drive(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("mul_busy%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("mul_busy%0d_valid", k), {31'd0, out_valid}, 32'd0);
      step();
    end
    chk("mul_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_result", out_result, 32'h00000001);
    chk("mul_rd", {27'd0, out_rd}, 32'd7);
    chk("mul_carry", {31'd0, out_carry}, 32'd0);
    chk("mul_in_ready", {31'd0, in_ready}, 32'd1);

    // MULHU high word, accepted the same edge the MUL result drains
    drive(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
    step();
    in_valid = 1'b0;
    chk("mulhu_start_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 32; k++) step();
    chk("mulhu_valid", {31'd0, out_valid}, 32'd1);
    chk("mulhu_result", out_result, 32'hFFFFFFFE);
    chk("mulhu_rd", {27'd0, out_rd}, 32'd8);
    step();
    chk("mulhu_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure stream ADD, XOR, SRA
    drive(4'd0, 32'd1, 32'd2, 5'd1);
    step();
    chk("bp_add_result", out_result, 32'd3);
    out_ready = 1'b0;
    drive(4'd4, 32'h000000F0, 32'h000000FF, 5'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_result", k), out_result, 32'd3);
      chk($sformatf("bp_hold%0d_rd", k), {27'd0, out_rd}, 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_xor_result", out_result, 32'h0000000F);
    chk("bp_xor_rd", {27'd0, out_rd}, 32'd2);
    drive(4'd9, 32'hFFFFFF00, 32'd4, 5'd3);
    step();
    chk("bp_sra_result", out_result, 32'hFFFFFFF0);
    chk("bp_sra_rd", {27'd0, out_rd}, 32'd3);
    in_valid = 1'b0;
    step();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Flush ten cycles into a MUL; an in_valid on the flush edge is dropped
    drive(4'd10, 32'd3, 32'd4, 5'd9);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    flush = 1'b1;
    drive(4'd0, 32'd100, 32'd1, 5'd5);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("flush_quiet%0d", k), {31'd0, out_valid}, 32'd0);
    end
    drive(4'd0, 32'd10, 32'd20, 5'd6);
    step();
    in_valid = 1'b0;
    chk("post_flush_result", out_result, 32'd30);
    chk("post_flush_rd", {27'd0, out_rd}, 32'd6);

    // Reset with a result pending under backpressure
    out_ready = 1'b0;
    step();
    chk("pend_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_pend_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pend_result", out_result, 32'd0);
    chk("rst_pend_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_pend_carry", {31'd0, out_carry}, 32'd0);
    chk("rst_pend_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-MUL: the product must never appear
    out_ready = 1'b1;
    drive(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mul_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mul_result", out_result, 32'd0);
    chk("rst_mul_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("rst_mul_quiet%0d", k), {31'd0, out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
